// File: rtl/ychg_sequencer.sv
// ychg_sequencer: walks the change-record SRAM and feeds one record at a time
// to the update-Y computation unit, with a per-record watchdog and progress
// counters.
module ychg_sequencer #(
    parameter int unsigned CHG_AW  = 11,
    parameter int unsigned TIMEOUT = 4095
) (
    input  logic              clock,
    input  logic              reset,
    // controller handshake
    input  logic              seq_start,
    input  logic [CHG_AW-1:0] seq_numChanges,
    // change-record SRAM
    output logic [CHG_AW-1:0] seq_chgMemAddr,
    output logic              seq_chgMemRd,
    input  logic [79:0]       seq_chgMemData,
    // computation unit
    output logic [15:0]       seq_chgRow,
    output logic [15:0]       seq_chgCol,
    output logic [23:0]       seq_chgReal,
    output logic [23:0]       seq_chgImg,
    output logic              seq_compEnable,
    input  logic              seq_dpDone,
    // status
    output logic              seq_busy,
    output logic              seq_allDone,
    output logic              seq_errTimeout,
    output logic [CHG_AW-1:0] seq_doneCount,
    output logic [CHG_AW-1:0] seq_skipCount
);

    localparam int unsigned       WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT);
    localparam logic [CHG_AW-1:0] CNT_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_FIRE      = 3'd3,
        S_WAIT_DONE = 3'd4,
        S_NEXT      = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    state_t             r_state;
    logic [CHG_AW-1:0]  r_count;
    logic [CHG_AW-1:0]  r_index;
    logic [CHG_AW-1:0]  r_addr;
    logic               r_rd;
    logic [15:0]        r_row;
    logic [15:0]        r_col;
    logic [23:0]        r_real;
    logic [23:0]        r_img;
    logic               r_en;
    logic               r_busy;
    logic               r_all_done;
    logic               r_err;
    logic [CHG_AW-1:0]  r_done_cnt;
    logic [CHG_AW-1:0]  r_skip_cnt;
    logic [WD_W-1:0]    r_wd;

    logic               w_zero_rec;
    logic [CHG_AW-1:0]  w_index_inc;
    logic               w_last;
    logic [CHG_AW-1:0]  w_done_inc;
    logic [CHG_AW-1:0]  w_skip_inc;

    // Record classification and saturating counter increments
    assign w_zero_rec  = (seq_chgMemData[47:0] == 48'd0);
    assign w_index_inc = r_index + CHG_AW'(1);
    assign w_last      = (w_index_inc == r_count);
    assign w_done_inc  = (r_done_cnt == CNT_MAX) ? r_done_cnt : r_done_cnt + CHG_AW'(1);
    assign w_skip_inc  = (r_skip_cnt == CNT_MAX) ? r_skip_cnt : r_skip_cnt + CHG_AW'(1);

    // Sequencer FSM with registered outputs; strobes are set on entry to
    // the state that owns them so they line up with that state's cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_index    <= '0;
            r_addr     <= '0;
            r_rd       <= 1'b0;
            r_row      <= '0;
            r_col      <= '0;
            r_real     <= '0;
            r_img      <= '0;
            r_en       <= 1'b0;
            r_busy     <= 1'b0;
            r_all_done <= 1'b0;
            r_err      <= 1'b0;
            r_done_cnt <= '0;
            r_skip_cnt <= '0;
            r_wd       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (seq_start) begin
                        r_count    <= seq_numChanges;
                        r_index    <= '0;
                        r_done_cnt <= '0;
                        r_skip_cnt <= '0;
                        r_err      <= 1'b0;
                        r_busy     <= 1'b1;
                        if (seq_numChanges == '0) begin
                            r_all_done <= 1'b1;
                            r_state    <= S_FINISH;
                        end else begin
                            r_addr  <= '0;
                            r_rd    <= 1'b1;
                            r_state <= S_FETCH;
                        end
                    end
                end

                S_FETCH: begin
                    r_rd    <= 1'b0;
                    r_state <= S_WAIT_DATA;
                end

                S_WAIT_DATA: begin
                    // SRAM data is valid this cycle; hold it until next capture
                    r_row  <= seq_chgMemData[79:64];
                    r_col  <= seq_chgMemData[63:48];
                    r_real <= seq_chgMemData[47:24];
                    r_img  <= seq_chgMemData[23:0];
                    if (w_zero_rec) begin
                        r_skip_cnt <= w_skip_inc;
                        r_state    <= S_NEXT;
                    end else begin
                        r_en    <= 1'b1;
                        r_state <= S_FIRE;
                    end
                end

                S_FIRE: begin
                    r_en    <= 1'b0;
                    r_wd    <= '0;
                    r_state <= S_WAIT_DONE;
                end

                S_WAIT_DONE: begin
                    // done has priority over the watchdog in the limit cycle
                    if (seq_dpDone) begin
                        r_done_cnt <= w_done_inc;
                        r_state    <= S_NEXT;
                    end else if (r_wd == WD_LIMIT) begin
                        r_err      <= 1'b1;
                        r_all_done <= 1'b1;
                        r_state    <= S_FINISH;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end

                S_NEXT: begin
                    r_index <= w_index_inc;
                    if (w_last) begin
                        r_all_done <= 1'b1;
                        r_state    <= S_FINISH;
                    end else begin
                        r_addr  <= w_index_inc;
                        r_rd    <= 1'b1;
                        r_state <= S_FETCH;
                    end
                end

                S_FINISH: begin
                    r_all_done <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end

                default: begin
                    r_rd       <= 1'b0;
                    r_en       <= 1'b0;
                    r_all_done <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

    // Output mapping
    assign seq_chgMemAddr = r_addr;
    assign seq_chgMemRd   = r_rd;
    assign seq_chgRow     = r_row;
    assign seq_chgCol     = r_col;
    assign seq_chgReal    = r_real;
    assign seq_chgImg     = r_img;
    assign seq_compEnable = r_en;
    assign seq_busy       = r_busy;
    assign seq_allDone    = r_all_done;
    assign seq_errTimeout = r_err;
    assign seq_doneCount  = r_done_cnt;
    assign seq_skipCount  = r_skip_cnt;

endmodule

// File: tb/tb_ychg_sequencer.sv
// tb_ychg_sequencer: directed bench with a record/address scoreboard and a
// datapath responder model.
module tb_ychg_sequencer;

    localparam int unsigned AW = 11;
    localparam int unsigned TO = 8;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          seq_start = 1'b0;
    logic [AW-1:0] seq_numChanges = '0;
    logic [AW-1:0] seq_chgMemAddr;
    logic          seq_chgMemRd;
    logic [79:0]   seq_chgMemData = '0;
    logic [15:0]   seq_chgRow, seq_chgCol;
    logic [23:0]   seq_chgReal, seq_chgImg;
    logic          seq_compEnable;
    logic          seq_dpDone;
    logic          seq_busy, seq_allDone, seq_errTimeout;
    logic [AW-1:0] seq_doneCount, seq_skipCount;

    logic          dp_resp = 1'b0;
    logic          dp_spur = 1'b0;
    logic          spur_arm = 1'b0;
    assign seq_dpDone = dp_resp | dp_spur;

    ychg_sequencer #(.CHG_AW(AW), .TIMEOUT(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .seq_start      (seq_start),
        .seq_numChanges (seq_numChanges),
        .seq_chgMemAddr (seq_chgMemAddr),
        .seq_chgMemRd   (seq_chgMemRd),
        .seq_chgMemData (seq_chgMemData),
        .seq_chgRow     (seq_chgRow),
        .seq_chgCol     (seq_chgCol),
        .seq_chgReal    (seq_chgReal),
        .seq_chgImg     (seq_chgImg),
        .seq_compEnable (seq_compEnable),
        .seq_dpDone     (seq_dpDone),
        .seq_busy       (seq_busy),
        .seq_allDone    (seq_allDone),
        .seq_errTimeout (seq_errTimeout),
        .seq_doneCount  (seq_doneCount),
        .seq_skipCount  (seq_skipCount)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // change-record SRAM: one-cycle read latency
    logic [79:0] mem [0:(1<<AW)-1];
    always @(posedge clock) if (seq_chgMemRd) seq_chgMemData <= mem[seq_chgMemAddr];

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total = n_total + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // scoreboard queues
    logic [79:0]   exp_rec_q [$];
    logic [AW-1:0] exp_addr_q [$];
    int            dly_q [$];

    int   n_en = 0, n_rd = 0, n_all = 0;
    int   en_cyc = 0, all_cyc = 0, t0cyc = 0;
    logic prev_en = 1'b0;

    // output monitor: compares records and addresses against the scoreboard
    always @(negedge clock) begin
        if (seq_compEnable) begin
            n_en = n_en + 1;
            en_cyc = cyc;
            check("enable_width", 128'(prev_en), 128'(0));
            check("enable_expected", 128'(exp_rec_q.size() != 0), 128'(1));
            if (exp_rec_q.size() != 0)
                check("record", 128'({seq_chgRow, seq_chgCol, seq_chgReal, seq_chgImg}),
                      128'(exp_rec_q.pop_front()));
        end
        prev_en = seq_compEnable;
        if (seq_chgMemRd) begin
            n_rd = n_rd + 1;
            check("read_expected", 128'(exp_addr_q.size() != 0), 128'(1));
            if (exp_addr_q.size() != 0)
                check("address", 128'(seq_chgMemAddr), 128'(exp_addr_q.pop_front()));
        end
        if (seq_allDone) begin
            n_all = n_all + 1;
            all_cyc = cyc;
        end
    end

    // datapath model: done d cycles after the enable cycle, 0 = never
    initial begin
        int d;
        forever begin
            @(negedge clock);
            if (seq_compEnable) begin
                d = (dly_q.size() != 0) ? dly_q.pop_front() : 0;
                if (d > 0) begin
                    repeat (d) @(negedge clock);
                    dp_resp = 1'b1;
                    @(negedge clock);
                    dp_resp = 1'b0;
                end
            end
        end
    end

    // spurious done pulse in every FETCH cycle while armed
    initial begin
        forever begin
            @(negedge clock);
            if (spur_arm && seq_chgMemRd) begin
                dp_spur = 1'b1;
                @(negedge clock);
                dp_spur = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    function automatic logic [127:0] all_outs();
        return 128'({seq_chgMemAddr, seq_chgMemRd, seq_chgRow, seq_chgCol, seq_chgReal,
                     seq_chgImg, seq_compEnable, seq_busy, seq_allDone, seq_errTimeout,
                     seq_doneCount, seq_skipCount});
    endfunction

    task automatic start_list(input int n);
        @(negedge clock);
        seq_numChanges = AW'(n);
        seq_start = 1'b1;
        @(negedge clock);
        seq_start = 1'b0;
        t0cyc = cyc;
    endtask

    task automatic wait_all(input int prev, input string tag);
        int k = 0;
        while (n_all == prev && k < 400) begin
            @(negedge clock);
            #1;
            k++;
        end
        check({tag, "_alldone_seen"}, 128'(n_all != prev), 128'(1));
        @(negedge clock);
    endtask

    logic [79:0] rec_a, rec0, rec1, rec2, rec3;
    int a0, e0, r0;

    initial begin
        rec_a = {16'd3, 16'd5, 24'h000100, 24'hFFFF00};
        rec0  = {16'h0010, 16'h0020, 24'h123456, 24'h000000};
        rec1  = {16'h0011, 16'h0021, 24'h000000, 24'h000001};
        rec2  = {16'h0012, 16'h0022, 24'h000000, 24'h000000};
        rec3  = {16'hFFFF, 16'hFFFF, 24'hFFFFFF, 24'hFFFFFF};

        // reset state
        repeat (3) @(negedge clock);
        check("reset_outputs", all_outs(), 128'(0));
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_outputs", all_outs(), 128'(0));

        // single record, done 6 cycles after the enable
        mem[0] = rec_a;
        exp_rec_q.push_back(rec_a); exp_addr_q.push_back(AW'(0)); dly_q.push_back(6);
        a0 = n_all; e0 = n_en;
        start_list(1);
        check("single_busy", 128'(seq_busy), 128'(1));
        wait_all(a0, "single");
        check("single_latency", 128'(all_cyc - t0cyc + 1), 128'(11));
        check("single_enables", 128'(n_en - e0), 128'(1));
        check("single_done", 128'(seq_doneCount), 128'(1));
        check("single_skip", 128'(seq_skipCount), 128'(0));
        check("single_alldone", 128'(n_all - a0), 128'(1));
        check("single_busy_low", 128'(seq_busy), 128'(0));
        check("single_hold", 128'({seq_chgRow, seq_chgCol, seq_chgReal, seq_chgImg}), 128'(rec_a));

        // mixed list with a zero record at index 2, random datapath latency
        mem[0] = rec0; mem[1] = rec1; mem[2] = rec2; mem[3] = rec3;
        exp_rec_q.push_back(rec0); exp_rec_q.push_back(rec1); exp_rec_q.push_back(rec3);
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(AW'(i));
        for (int i = 0; i < 3; i++) dly_q.push_back(int'($urandom_range(1, 9)));
        a0 = n_all; e0 = n_en; r0 = n_rd;
        start_list(4);
        wait_all(a0, "mixed");
        check("mixed_enables", 128'(n_en - e0), 128'(3));
        check("mixed_reads", 128'(n_rd - r0), 128'(4));
        check("mixed_done", 128'(seq_doneCount), 128'(3));
        check("mixed_skip", 128'(seq_skipCount), 128'(1));
        check("mixed_err", 128'(seq_errTimeout), 128'(0));
        check("mixed_addrq_empty", 128'(exp_addr_q.size()), 128'(0));
        check("mixed_recq_empty", 128'(exp_rec_q.size()), 128'(0));

        // empty list
        a0 = n_all; e0 = n_en; r0 = n_rd;
        start_list(0);
        wait_all(a0, "empty");
        check("empty_latency", 128'(all_cyc - t0cyc + 1), 128'(1));
        check("empty_reads", 128'(n_rd - r0), 128'(0));
        check("empty_enables", 128'(n_en - e0), 128'(0));
        check("empty_done", 128'(seq_doneCount), 128'(0));

        // watchdog: record 1 never completes, record 2 must not be fetched
        exp_rec_q.push_back(rec0); exp_rec_q.push_back(rec1);
        exp_addr_q.push_back(AW'(0)); exp_addr_q.push_back(AW'(1));
        dly_q.push_back(3); dly_q.push_back(0);
        a0 = n_all; r0 = n_rd;
        start_list(3);
        wait_all(a0, "wdog");
        check("wdog_err", 128'(seq_errTimeout), 128'(1));
        check("wdog_done", 128'(seq_doneCount), 128'(1));
        check("wdog_alldone", 128'(n_all - a0), 128'(1));
        check("wdog_abort_cycle", 128'(all_cyc - en_cyc), 128'(TO + 2));
        check("wdog_reads", 128'(n_rd - r0), 128'(2));
        check("wdog_addrq_empty", 128'(exp_addr_q.size()), 128'(0));

        // spurious start while busy and done pulses during FETCH;
        // first and last records complete exactly at the watchdog limit
        exp_rec_q.push_back(rec0); exp_rec_q.push_back(rec1); exp_rec_q.push_back(rec3);
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(AW'(i));
        dly_q.push_back(TO + 1); dly_q.push_back(1); dly_q.push_back(TO + 1);
        spur_arm = 1'b1;
        a0 = n_all; e0 = n_en; r0 = n_rd;
        start_list(4);
        repeat (3) @(negedge clock);
        seq_numChanges = AW'(1);
        seq_start = 1'b1;
        @(negedge clock);
        seq_start = 1'b0;
        wait_all(a0, "spur");
        spur_arm = 1'b0;
        check("spur_done", 128'(seq_doneCount), 128'(3));
        check("spur_skip", 128'(seq_skipCount), 128'(1));
        check("spur_err", 128'(seq_errTimeout), 128'(0));
        check("spur_reads", 128'(n_rd - r0), 128'(4));
        repeat (5) @(negedge clock);
        check("spur_enables", 128'(n_en - e0), 128'(3));
        check("spur_alldone", 128'(n_all - a0), 128'(1));
        check("spur_idle", 128'(seq_busy), 128'(0));

        // reset in WAIT_DONE aborts without an allDone pulse
        mem[0] = rec_a;
        exp_rec_q.push_back(rec_a); exp_addr_q.push_back(AW'(0)); dly_q.push_back(0);
        a0 = n_all;
        start_list(1);
        repeat (5) @(negedge clock);
        check("pre_reset_busy", 128'(seq_busy), 128'(1));
        reset = 1'b1;
        @(negedge clock);
        check("midrun_reset_outputs", all_outs(), 128'(0));
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check("midrun_no_alldone", 128'(n_all - a0), 128'(0));

        // normal run after reset
        exp_rec_q.push_back(rec_a); exp_addr_q.push_back(AW'(0)); dly_q.push_back(2);
        a0 = n_all;
        start_list(1);
        wait_all(a0, "after_reset");
        check("after_reset_done", 128'(seq_doneCount), 128'(1));
        check("after_reset_alldone", 128'(n_all - a0), 128'(1));
        check("after_reset_recq_empty", 128'(exp_rec_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
